// File: rtl/emu_time_ctrl_pkg.sv
// Shared types for the emulation time controller: FSM state encoding and
// the default time word format.
package time_package;

   localparam int unsigned TIME_W_DEF = 32;

   typedef logic [TIME_W_DEF-1:0] TIME_FORMAT;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } emu_state_t;

   // True when the FSM state plus the user controls ask for an advance;
   // stop and channel-mask gating are applied by the caller.
   function automatic logic advance_req(emu_state_t st, logic pause_i, logic step_i);
      return ((st == RUN) && !pause_i) || ((st == PAUSE) && step_i);
   endfunction

endpackage

// File: rtl/emu_time_ctrl_if.sv
// Control/status bundle between the emulation host (master) and the time
// controller (slave). Control inputs are level signals sampled on clk_orig.
interface emu_time_ctrl_if #(
   parameter int N          = 2,
   parameter int TIME_WIDTH = 32,
   parameter int CNT_WIDTH  = 32
);
   logic                            start;
   logic                            pause;
   logic                            step;
   logic [TIME_WIDTH-1:0]           time_stop;
   logic [N-1:0]                    chan_en;
   logic [N-1:0][TIME_WIDTH-1:0]    time_in;

   logic [TIME_WIDTH-1:0]           time_next;
   logic [TIME_WIDTH-1:0]           time_curr;
   logic [N-1:0]                    time_eq;
   logic                            clk_en;
   logic [1:0]                      state;
   logic                            sim_done;
   logic                            err_backwards;
   logic [CNT_WIDTH-1:0]            step_count;

   modport master (
      output start, pause, step, time_stop, chan_en, time_in,
      input  time_next, time_curr, time_eq, clk_en, state,
             sim_done, err_backwards, step_count
   );

   modport slave (
      input  start, pause, step, time_stop, chan_en, time_in,
      output time_next, time_curr, time_eq, clk_en, state,
             sim_done, err_backwards, step_count
   );

endinterface

// File: rtl/emu_time_ctrl_min.sv
// Minimum search over the enabled channel times plus per-channel ownership
// flags; falls back to the current time when no channel is enabled.
module time_min #(
   parameter int N          = 2,
   parameter int TIME_WIDTH = 32
) (
   input  logic [N-1:0]                 i_chan_en,
   input  logic [N-1:0][TIME_WIDTH-1:0] i_time_in,
   input  logic [TIME_WIDTH-1:0]        i_time_curr,
   output logic [TIME_WIDTH-1:0]        o_time_next,
   output logic [N-1:0]                 o_time_eq,
   output logic                         o_any_en
);

   logic [TIME_WIDTH-1:0] w_min;
   logic                  w_any;
   logic [TIME_WIDTH-1:0] w_next;
   logic [N-1:0]          w_eq;

   always_comb begin
      w_min = '1;
      w_any = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (i_chan_en[i] && (!w_any || (i_time_in[i] < w_min))) begin
            w_min = i_time_in[i];
            w_any = 1'b1;
         end
      end
   end

   assign w_next = w_any ? w_min : i_time_curr;

   // Ties are legal, so every enabled channel matching the minimum is flagged.
   always_comb begin
      w_eq = '0;
      for (int i = 0; i < N; i++) begin
         w_eq[i] = i_chan_en[i] && (i_time_in[i] == w_next);
      end
   end

   assign o_time_next = w_next;
   assign o_time_eq   = w_eq;
   assign o_any_en    = w_any;

endmodule

// File: rtl/emu_time_ctrl.sv
// Emulation time controller: picks the earliest pending channel event and
// gates clk_sys one advance per enabled cycle until the stop time is reached.
module emu_time_ctrl
   import time_package::*;
#(
   parameter int N          = 2,
   parameter int TIME_WIDTH = 32,
   parameter int CNT_WIDTH  = 32
) (
   input  logic           clk_orig,
   input  logic           rst,
   emu_time_ctrl_if.slave bus
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   emu_state_t              r_state;
   emu_state_t              w_state_nxt;
   logic [TIME_WIDTH-1:0]   r_time_curr;
   logic [CNT_WIDTH-1:0]    r_step_count;
   logic                    r_err_backwards;

   logic [TIME_WIDTH-1:0]   w_time_next;
   logic [N-1:0]            w_time_eq;
   logic                    w_any_en;
   logic                    w_stop_hit;
   logic                    w_clk_en;

   time_min #(
      .N          (N),
      .TIME_WIDTH (TIME_WIDTH)
   ) u_time_min (
      .i_chan_en   (bus.chan_en),
      .i_time_in   (bus.time_in),
      .i_time_curr (r_time_curr),
      .o_time_next (w_time_next),
      .o_time_eq   (w_time_eq),
      .o_any_en    (w_any_en)
   );

   assign w_stop_hit = (r_time_curr >= bus.time_stop);

   // rst forces the gate closed so no clk_sys pulse escapes during reset.
   assign w_clk_en = !rst && !w_stop_hit && w_any_en &&
                     advance_req(r_state, bus.pause, bus.step);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (bus.start) w_state_nxt = RUN;
         end
         RUN: begin
            if (w_stop_hit)     w_state_nxt = DONE;
            else if (bus.pause) w_state_nxt = PAUSE;
         end
         PAUSE: begin
            if (w_stop_hit)     w_state_nxt = DONE;
            else if (bus.start) w_state_nxt = RUN;
         end
         DONE: begin
            w_state_nxt = DONE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_orig) begin
      if (rst) begin
         r_state         <= IDLE;
         r_time_curr     <= '0;
         r_step_count    <= '0;
         r_err_backwards <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_clk_en) begin
            r_time_curr <= w_time_next;
            if (r_step_count != '1) r_step_count <= r_step_count + CNT_ONE;
            if (w_time_next < r_time_curr) r_err_backwards <= 1'b1;
         end
      end
   end

   assign bus.time_next     = w_time_next;
   assign bus.time_curr     = r_time_curr;
   assign bus.time_eq       = w_time_eq;
   assign bus.clk_en        = w_clk_en;
   assign bus.state         = r_state;
   assign bus.sim_done      = (r_state == DONE);
   assign bus.err_backwards = r_err_backwards;
   assign bus.step_count    = r_step_count;

endmodule

// File: doc/emu_time_ctrl.md
EMU_TIME_CTRL -- requirements
Module: emu_time_ctrl

Interface
REQ-001 SHALL have parameter N, default 2: number of time-producing channels, range 1..16.
REQ-002 SHALL have parameter TIME_WIDTH, default 32: width of all time words, unsigned fixed-point.
REQ-003 SHALL have parameter CNT_WIDTH, default 32: width of step_count.
REQ-004 SHALL have port clk_orig, input, 1: free-running ungated clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: run request.
REQ-007 SHALL have port pause, input, 1: pause request.
REQ-008 SHALL have port step, input, 1: single-advance request while paused.
REQ-009 SHALL have port time_stop, input, TIME_WIDTH: emulated stop time.
REQ-010 SHALL have port chan_en, input, N: per-channel participation mask.
REQ-011 SHALL have port time_in, input, N x TIME_WIDTH: next event time reported by each channel.
REQ-012 SHALL have port time_next, output, TIME_WIDTH: minimum enabled time_in.
REQ-013 SHALL have port time_curr, output, TIME_WIDTH: registered current emulated time.
REQ-014 SHALL have port time_eq, output, N: channel i owns the next event.
REQ-015 SHALL have port clk_en, output, 1: enable for downstream clkgate producing clk_sys.
REQ-016 SHALL have port state, output, 2: FSM state code.
REQ-017 SHALL have ports sim_done, err_backwards (output, 1 each) and step_count (output, CNT_WIDTH).

Function
REQ-018 SHALL implement states IDLE=0, RUN=1, PAUSE=2, DONE=3.
REQ-019 SHALL compute time_next combinationally as the minimum of time_in[i] over i with chan_en[i]=1; ties are legal.
REQ-020 SHALL drive time_eq[i] = chan_en[i] AND (time_in[i] == time_next); several bits may be high.
REQ-021 SHALL, with chan_en all zero, drive time_next = time_curr, time_eq = 0, clk_en = 0.
REQ-022 SHALL define stop_hit = (time_curr >= time_stop), unsigned compare.
REQ-023 SHALL drive clk_en combinationally: 1 iff not stop_hit, chan_en != 0, and either (RUN and pause=0) or (PAUSE and step=1).
REQ-024 SHALL, on each edge with clk_en=1, load time_curr <= time_next and increment step_count, saturating at all-ones.
REQ-025 SHALL transition IDLE->RUN on start; start ignored in RUN and DONE.
REQ-026 SHALL transition RUN->PAUSE on pause; that cycle performs no advance.
REQ-027 SHALL transition PAUSE->RUN on start; start and step together advance once and enter RUN.
REQ-028 SHALL keep PAUSE on step alone after exactly one advance; step held high advances once per cycle.
REQ-029 SHALL transition RUN or PAUSE -> DONE on the edge where stop_hit=1, with priority over start/pause/step.
REQ-030 SHALL hold DONE, with sim_done=1 and clk_en=0, until rst.
REQ-031 SHALL set err_backwards (sticky until rst) on an edge with clk_en=1 and time_next < time_curr.

Reset
REQ-032 SHALL on rst: state=IDLE, time_curr=0, step_count=0, sim_done=0, err_backwards=0.
REQ-033 SHALL give rst priority over all inputs, including mid-RUN and in DONE.
REQ-034 SHALL hold clk_en=0 during the rst cycle.

Structure
REQ-035 SHALL place the state enum emu_state_t and the TIME_FORMAT typedef in time_package.
REQ-036 SHALL isolate the min/equality logic in one sub-module, time_min, parameterised by N and TIME_WIDTH.
REQ-037 SHALL keep the FSM, counters and flags in emu_time_ctrl.

Verification
REQ-038 SHALL test basic run: N=2, both enabled, time_in={10,25}, time_stop=100, start -> time_eq=01, clk_en=1, time_curr=10 next edge.
REQ-039 SHALL test mask: chan_en=10, time_in={5,40} -> time_next=40, time_eq=10; chan_en=00 -> clk_en=0, time_curr frozen.
REQ-040 SHALL test pause/step: pause in RUN -> no advance that cycle; three one-cycle step pulses -> step_count +3, state stays PAUSE.
REQ-041 SHALL test stop: time_stop=0, start -> RUN for one cycle, zero advances, DONE with sim_done=1; start ignored until rst.
REQ-042 SHALL test error: time_curr=50, enabled time_in=30 while RUN -> err_backwards=1 and stays 1 until rst.
REQ-043 SHALL test reset mid-RUN: time_curr=70, step_count=7, rst -> all outputs return to reset values next edge.
